// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - shared types and limits for the PLIC gateway controller
package plic_pkg;

  localparam int MAX_SRC = 31;
  localparam int MAX_TGT = 32;
  localparam int ID_W    = 5;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_target_arb.sv
// rtl/plic_target_arb.sv - best pending source for one target (highest priority, lowest ID on ties)
module plic_target_arb
  import plic_pkg::*;
#(
  parameter int SRC_N  = 1,
  parameter int PRIO_W = 1
) (
  input  logic [SRC_N:0]             pending,
  input  logic [SRC_N:0]             enable,
  input  logic [SRC_N:0][PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]          threshold,
  output logic [ID_W-1:0]            best_id,
  output logic                       best_valid
);

  logic [PRIO_W-1:0] best_prio;

  // Only a strictly higher priority displaces the current pick, so ties keep the lower ID.
  // Priority 0 can never exceed a threshold, so it never becomes a candidate.
  always_comb begin
    best_id    = '0;
    best_valid = 1'b0;
    best_prio  = '0;
    for (int i = 0; i <= SRC_N; i++) begin
      if (pending[i] && enable[i] && (prio[i] > threshold) &&
          (!best_valid || (prio[i] > best_prio))) begin
        best_id    = ID_W'(i);
        best_valid = 1'b1;
        best_prio  = prio[i];
      end
    end
  end

endmodule

// File: rtl/plic_gateway_ctrl.sv
// rtl/plic_gateway_ctrl.sv - PLIC gateways, per-target arbitration and claim/complete handling
module plic_gateway_ctrl
  import plic_pkg::*;
#(
  parameter int SRC_N  = 1,
  parameter int TGT_N  = 1,
  parameter int PRIO_W = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SRC_N:1]                irq_src,
  input  logic                          claim_valid,
  input  logic [ID_W-1:0]               claim_tgt,
  input  logic                          complete_valid,
  input  logic [ID_W-1:0]               complete_src,
  input  logic [ID_W-1:0]               complete_tgt,
  input  logic [SRC_N:0][PRIO_W-1:0]    cfg_int_prio,
  input  logic [TGT_N-1:0][SRC_N:0]     cfg_int_enable,
  input  logic [TGT_N-1:0][PRIO_W-1:0]  cfg_threshold,
  output logic [SRC_N:0]                int_pending,
  output logic [ID_W-1:0]               claim_src,
  output logic [TGT_N-1:0]              irq_out
);

  logic [SRC_N:1]   sync1_q, sync1_d;
  logic [SRC_N:1]   sync2_q, sync2_d;
  gw_state_e        state_q [SRC_N:1];
  gw_state_e        state_d [SRC_N:1];
  logic [ID_W-1:0]  owner_q [SRC_N:1];
  logic [ID_W-1:0]  owner_d [SRC_N:1];
  logic [TGT_N-1:0] irq_out_q, irq_out_d;

  logic [TGT_N-1:0][ID_W-1:0] best_id;
  logic [TGT_N-1:0]           best_valid;

  always_comb begin
    int_pending[0] = 1'b0;
    for (int i = 1; i <= SRC_N; i++) begin
      int_pending[i] = (state_q[i] == GW_PENDING);
    end
  end

  for (genvar t = 0; t < TGT_N; t++) begin : g_tgt
    plic_target_arb #(
      .SRC_N  (SRC_N),
      .PRIO_W (PRIO_W)
    ) u_arb (
      .pending    (int_pending),
      .enable     (cfg_int_enable[t]),
      .prio       (cfg_int_prio),
      .threshold  (cfg_threshold[t]),
      .best_id    (best_id[t]),
      .best_valid (best_valid[t])
    );
  end

  // An out-of-range target matches no arbiter and reads back 0, so its claim is inert.
  always_comb begin
    claim_src = '0;
    for (int t = 0; t < TGT_N; t++) begin
      if (claim_tgt == ID_W'(t)) begin
        claim_src = best_id[t];
      end
    end
  end

  always_comb begin
    sync1_d   = irq_src;
    sync2_d   = sync1_q;
    irq_out_d = best_valid;
    for (int i = 1; i <= SRC_N; i++) begin
      state_d[i] = state_q[i];
      owner_d[i] = owner_q[i];
      case (state_q[i])
        GW_IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = GW_PENDING;
          end
        end
        GW_PENDING: begin
          if (claim_valid && (claim_src == ID_W'(i))) begin
            state_d[i] = GW_CLAIMED;
            owner_d[i] = claim_tgt;
          end
        end
        GW_CLAIMED: begin
          if (complete_valid && (complete_src == ID_W'(i)) && (complete_tgt == owner_q[i])) begin
            state_d[i] = GW_IDLE;
          end
        end
        default: state_d[i] = GW_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      irq_out_q <= '0;
      for (int i = 1; i <= SRC_N; i++) begin
        state_q[i] <= GW_IDLE;
        owner_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      irq_out_q <= irq_out_d;
      for (int i = 1; i <= SRC_N; i++) begin
        state_q[i] <= state_d[i];
        owner_q[i] <= owner_d[i];
      end
    end
  end

  assign irq_out = irq_out_q;

endmodule

// File: tb/tb_plic_gateway_ctrl.sv
// tb/tb_plic_gateway_ctrl.sv - randomized and directed self-checking bench for plic_gateway_ctrl
module tb_plic_gateway_ctrl;

  localparam int SRC_N  = 3;
  localparam int TGT_N  = 2;
  localparam int PRIO_W = 2;

  logic                          clk;
  logic                          rst_n;
  logic [SRC_N:1]                irq_src;
  logic                          claim_valid;
  logic [4:0]                    claim_tgt;
  logic                          complete_valid;
  logic [4:0]                    complete_src;
  logic [4:0]                    complete_tgt;
  logic [SRC_N:0][PRIO_W-1:0]    cfg_int_prio;
  logic [TGT_N-1:0][SRC_N:0]     cfg_int_enable;
  logic [TGT_N-1:0][PRIO_W-1:0]  cfg_threshold;
  logic [SRC_N:0]                int_pending;
  logic [4:0]                    claim_src;
  logic [TGT_N-1:0]              irq_out;

  plic_gateway_ctrl #(
    .SRC_N  (SRC_N),
    .TGT_N  (TGT_N),
    .PRIO_W (PRIO_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_src        (irq_src),
    .claim_valid    (claim_valid),
    .claim_tgt      (claim_tgt),
    .complete_valid (complete_valid),
    .complete_src   (complete_src),
    .complete_tgt   (complete_tgt),
    .cfg_int_prio   (cfg_int_prio),
    .cfg_int_enable (cfg_int_enable),
    .cfg_threshold  (cfg_threshold),
    .int_pending    (int_pending),
    .claim_src      (claim_src),
    .irq_out        (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = pending, 2 = claimed.
  int m_st  [1:SRC_N];
  int m_own [1:SRC_N];
  bit m_s1  [1:SRC_N];
  bit m_s2  [1:SRC_N];
  bit m_irq [TGT_N];

  function automatic void model_reset();
    for (int i = 1; i <= SRC_N; i++) begin
      m_st[i] = 0; m_own[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
    end
    for (int t = 0; t < TGT_N; t++) m_irq[t] = 0;
  endfunction

  function automatic bit is_cand(int t, int i);
    return (m_st[i] == 1) && cfg_int_enable[t][i] &&
           (int'(cfg_int_prio[i]) > int'(cfg_threshold[t]));
  endfunction

  // Two passes: find the top priority, then the first ID reaching it.
  function automatic int best_of(int t);
    int top = -1;
    for (int i = 1; i <= SRC_N; i++)
      if (is_cand(t, i) && int'(cfg_int_prio[i]) > top) top = int'(cfg_int_prio[i]);
    if (top < 0) return 0;
    for (int i = 1; i <= SRC_N; i++)
      if (is_cand(t, i) && int'(cfg_int_prio[i]) == top) return i;
    return 0;
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] v = '0;
    for (int i = 1; i <= SRC_N; i++) v[i] = (m_st[i] == 1);
    return v;
  endfunction

  function automatic logic [31:0] exp_irq();
    logic [31:0] v = '0;
    for (int t = 0; t < TGT_N; t++) v[t] = m_irq[t];
    return v;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    int exp_claim;
    int nst [1:SRC_N];
    int nown [1:SRC_N];
    bit nirq [TGT_N];
    if (!rst_n) model_reset();
    #3;
    exp_claim = (int'(claim_tgt) < TGT_N) ? best_of(int'(claim_tgt)) : 0;
    chk("claim_src", {27'd0, claim_src}, exp_claim);
    for (int i = 1; i <= SRC_N; i++) begin
      nst[i] = m_st[i]; nown[i] = m_own[i];
      if (m_st[i] == 0 && m_s2[i]) nst[i] = 1;
      if (m_st[i] == 1 && claim_valid && exp_claim == i) begin
        nst[i] = 2; nown[i] = int'(claim_tgt);
      end
      if (m_st[i] == 2 && complete_valid && int'(complete_src) == i &&
          int'(complete_tgt) == m_own[i]) nst[i] = 0;
    end
    for (int t = 0; t < TGT_N; t++) nirq[t] = (best_of(t) != 0);
    @(posedge clk);
    if (rst_n) begin
      for (int i = 1; i <= SRC_N; i++) begin
        m_st[i] = nst[i]; m_own[i] = nown[i];
        m_s2[i] = m_s1[i]; m_s1[i] = irq_src[i];
      end
      for (int t = 0; t < TGT_N; t++) m_irq[t] = nirq[t];
    end else begin
      model_reset();
    end
    #1;
    chk("int_pending", {28'd0, int_pending}, exp_pend());
    chk("irq_out", {30'd0, irq_out}, exp_irq());
  endtask

  task automatic idle_bus();
    claim_valid = 0; claim_tgt = 0;
    complete_valid = 0; complete_src = 0; complete_tgt = 0;
  endtask

  initial begin
    rst_n = 0; irq_src = '0; idle_bus();
    cfg_int_prio = '0; cfg_int_enable = '0; cfg_threshold = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_pending", {28'd0, int_pending}, 32'd0);
    chk("reset_irq", {30'd0, irq_out}, 32'd0);
    rst_n = 1;

    // Latency: source 1, target 0 enabled
    cfg_int_prio[1] = 2; cfg_int_enable[0] = 4'b1110; cfg_threshold[0] = 0;
    irq_src = 3'b001;
    step(); step(); step();
    chk("lat_pending", {28'd0, int_pending}, 32'h2);
    step();
    chk("lat_irq", {30'd0, irq_out}, 32'h1);

    // Equal priorities: lowest ID first, then next best
    cfg_int_prio[2] = 3; cfg_int_prio[3] = 3; irq_src = 3'b111;
    step(); step(); step();
    claim_valid = 1; claim_tgt = 0;
    #2 chk("claim_first", {27'd0, claim_src}, 32'd2);
    step();
    chk("claimed_not_pending", {31'd0, int_pending[2]}, 32'd0);
    #2 chk("claim_next", {27'd0, claim_src}, 32'd3);
    step();

    // Completes: wrong owner ignored, right owner frees
    idle_bus(); irq_src = 3'b101;
    complete_valid = 1; complete_src = 2; complete_tgt = 1;
    step();
    complete_tgt = 0;
    step();
    idle_bus();
    step();
    chk("completed_idle", {31'd0, int_pending[2]}, 32'd0);
    complete_valid = 1; complete_src = 3; complete_tgt = 0;
    step();
    chk("complete_line_high", {31'd0, int_pending[3]}, 32'd0);
    idle_bus();
    step();
    chk("repend", {31'd0, int_pending[3]}, 32'd1);

    // Threshold equals priority: no interrupt, claim inert
    cfg_threshold[0] = 2; cfg_int_enable[0] = 4'b0010;
    step();
    chk("thr_irq", {31'd0, irq_out[0]}, 32'd0);
    claim_valid = 1; claim_tgt = 0;
    #2 chk("thr_claim", {27'd0, claim_src}, 32'd0);
    step();
    chk("thr_still_pending", {31'd0, int_pending[1]}, 32'd1);

    // Out-of-range target
    claim_tgt = 5'd7; cfg_int_enable[1] = 4'b1110; cfg_threshold[1] = 0;
    step();
    chk("oor_still_pending", {31'd0, int_pending[1]}, 32'd1);

    // Simultaneous claim of 1 and complete of 2
    idle_bus(); cfg_threshold[0] = 0; cfg_int_enable[0] = 4'b1110; cfg_int_enable[1] = 4'b0000;
    irq_src = 3'b111;
    step(); step(); step();
    claim_valid = 1; claim_tgt = 0;
    step();
    irq_src = 3'b101; cfg_int_enable[0] = 4'b0010;
    claim_valid = 1; claim_tgt = 0;
    complete_valid = 1; complete_src = 2; complete_tgt = 0;
    step();
    chk("both_applied", {30'd0, int_pending[2:1]}, 32'd0);
    idle_bus();
    step();

    // Reset while source 1 claimed
    irq_src = 3'b001; claim_valid = 1; claim_tgt = 0;
    rst_n = 0;
    #1;
    chk("rst_now_pending", {28'd0, int_pending}, 32'd0);
    chk("rst_now_irq", {30'd0, irq_out}, 32'd0);
    step();
    idle_bus(); rst_n = 1;
    step(); step();
    chk("rst_repend_early", {31'd0, int_pending[1]}, 32'd0);
    step();
    chk("rst_repend", {31'd0, int_pending[1]}, 32'd1);

    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) begin
        for (int i = 0; i <= SRC_N; i++) cfg_int_prio[i] = PRIO_W'($urandom_range(0, 3));
        for (int t = 0; t < TGT_N; t++) begin
          cfg_int_enable[t] = 4'($urandom);
          cfg_threshold[t]  = PRIO_W'($urandom_range(0, 1));
        end
      end
      for (int i = 1; i <= SRC_N; i++)
        if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
      claim_valid    = ($urandom_range(0, 1) == 1);
      claim_tgt      = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, TGT_N - 1));
      complete_valid = ($urandom_range(0, 1) == 1);
      complete_src   = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, SRC_N));
      complete_tgt   = 5'($urandom_range(0, TGT_N));
      rst_n          = ($urandom_range(0, 299) != 0);
      step();
      rst_n = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
